// File: rtl/mem_wb.sv
// MEM/WB pipeline register with an LLbit register and its bypass toward the MEM stage.
// Priority per edge: rst, flush, bubble (MEM stalled, WB running), advance, hold.
module mem_wb (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic        mem_whilo,
    input  logic [31:0] mem_hi,
    input  logic [31:0] mem_lo,
    input  logic        mem_LLbit_we,
    input  logic        mem_LLbit_value,
    input  logic        mem_cp0_reg_we,
    input  logic [4:0]  mem_cp0_reg_waddr,
    input  logic [31:0] mem_cp0_reg_wdata,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        wb_whilo,
    output logic [31:0] wb_hi,
    output logic [31:0] wb_lo,
    output logic        wb_LLbit_we,
    output logic        wb_LLbit_value,
    output logic        wb_cp0_reg_we,
    output logic [4:0]  wb_cp0_reg_waddr,
    output logic [31:0] wb_cp0_reg_wdata,
    output logic        llbit_o
);

    typedef struct packed {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        llbit_we;
        logic        llbit_value;
        logic        cp0_we;
        logic [4:0]  cp0_waddr;
        logic [31:0] cp0_wdata;
    } wb_bundle_t;

    wb_bundle_t mem_in;
    wb_bundle_t wb_d, wb_q;
    logic       llbit_d, llbit_q;

    // Only the MEM and WB stall bits matter to this stage.
    logic unused_stall;
    assign unused_stall = ^stall[3:0];

    assign mem_in = '{
        wd:          mem_wd,
        wreg:        mem_wreg,
        wdata:       mem_wdata,
        whilo:       mem_whilo,
        hi:          mem_hi,
        lo:          mem_lo,
        llbit_we:    mem_LLbit_we,
        llbit_value: mem_LLbit_value,
        cp0_we:      mem_cp0_reg_we,
        cp0_waddr:   mem_cp0_reg_waddr,
        cp0_wdata:   mem_cp0_reg_wdata
    };

    always_comb begin
        wb_d = wb_q;
        if (flush) begin
            wb_d = '0;
        end else if (stall[4] && !stall[5]) begin
            wb_d = '0;
        end else if (!stall[4]) begin
            wb_d = mem_in;
        end
    end

    // The LLbit commits from the WB-stage write; a flush clears it even if a write is pending.
    always_comb begin
        llbit_d = llbit_q;
        if (flush) begin
            llbit_d = 1'b0;
        end else if (wb_q.llbit_we) begin
            llbit_d = wb_q.llbit_value;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_q    <= '0;
            llbit_q <= 1'b0;
        end else begin
            wb_q    <= wb_d;
            llbit_q <= llbit_d;
        end
    end

    assign wb_wd            = wb_q.wd;
    assign wb_wreg          = wb_q.wreg;
    assign wb_wdata         = wb_q.wdata;
    assign wb_whilo         = wb_q.whilo;
    assign wb_hi            = wb_q.hi;
    assign wb_lo            = wb_q.lo;
    assign wb_LLbit_we      = wb_q.llbit_we;
    assign wb_LLbit_value   = wb_q.llbit_value;
    assign wb_cp0_reg_we    = wb_q.cp0_we;
    assign wb_cp0_reg_waddr = wb_q.cp0_waddr;
    assign wb_cp0_reg_wdata = wb_q.cp0_wdata;

    assign llbit_o = wb_q.llbit_we ? wb_q.llbit_value : llbit_q;

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb: advance, bubble, hold, LL/SC bypass, flush, HI/LO/CP0 and reset.
module tb_mem_wb;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_LLbit_we;
    logic        mem_LLbit_value;
    logic        mem_cp0_reg_we;
    logic [4:0]  mem_cp0_reg_waddr;
    logic [31:0] mem_cp0_reg_wdata;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        wb_LLbit_we;
    logic        wb_LLbit_value;
    logic        wb_cp0_reg_we;
    logic [4:0]  wb_cp0_reg_waddr;
    logic [31:0] wb_cp0_reg_wdata;
    logic        llbit_o;

    int checks   = 0;
    int failures = 0;

    mem_wb dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .flush             (flush),
        .mem_wd            (mem_wd),
        .mem_wreg          (mem_wreg),
        .mem_wdata         (mem_wdata),
        .mem_whilo         (mem_whilo),
        .mem_hi            (mem_hi),
        .mem_lo            (mem_lo),
        .mem_LLbit_we      (mem_LLbit_we),
        .mem_LLbit_value   (mem_LLbit_value),
        .mem_cp0_reg_we    (mem_cp0_reg_we),
        .mem_cp0_reg_waddr (mem_cp0_reg_waddr),
        .mem_cp0_reg_wdata (mem_cp0_reg_wdata),
        .wb_wd             (wb_wd),
        .wb_wreg           (wb_wreg),
        .wb_wdata          (wb_wdata),
        .wb_whilo          (wb_whilo),
        .wb_hi             (wb_hi),
        .wb_lo             (wb_lo),
        .wb_LLbit_we       (wb_LLbit_we),
        .wb_LLbit_value    (wb_LLbit_value),
        .wb_cp0_reg_we     (wb_cp0_reg_we),
        .wb_cp0_reg_waddr  (wb_cp0_reg_waddr),
        .wb_cp0_reg_wdata  (wb_cp0_reg_wdata),
        .llbit_o           (llbit_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".wd"},        32'(wb_wd), 32'd0);
        chk({tag, ".wreg"},      32'(wb_wreg), 32'd0);
        chk({tag, ".wdata"},     wb_wdata, 32'd0);
        chk({tag, ".whilo"},     32'(wb_whilo), 32'd0);
        chk({tag, ".hi"},        wb_hi, 32'd0);
        chk({tag, ".lo"},        wb_lo, 32'd0);
        chk({tag, ".ll_we"},     32'(wb_LLbit_we), 32'd0);
        chk({tag, ".ll_val"},    32'(wb_LLbit_value), 32'd0);
        chk({tag, ".cp0_we"},    32'(wb_cp0_reg_we), 32'd0);
        chk({tag, ".cp0_waddr"}, 32'(wb_cp0_reg_waddr), 32'd0);
        chk({tag, ".cp0_wdata"}, wb_cp0_reg_wdata, 32'd0);
    endtask

    task automatic clear_inputs();
        mem_wd = '0; mem_wreg = 0; mem_wdata = '0; mem_whilo = 0;
        mem_hi = '0; mem_lo = '0; mem_LLbit_we = 0; mem_LLbit_value = 0;
        mem_cp0_reg_we = 0; mem_cp0_reg_waddr = '0; mem_cp0_reg_wdata = '0;
    endtask

    initial begin
        rst = 1; flush = 0; stall = 6'b000000;
        clear_inputs();
        step();
        chk_all_zero("reset");
        chk("reset.llbit_o", 32'(llbit_o), 32'd0);
        rst = 0;

        // Advance
        mem_wd = 5'd3; mem_wreg = 1; mem_wdata = 32'hDEADBEEF;
        step();
        chk("adv.wd", 32'(wb_wd), 32'd3);
        chk("adv.wreg", 32'(wb_wreg), 32'd1);
        chk("adv.wdata", wb_wdata, 32'hDEADBEEF);

        // Bubble
        stall = 6'b010000;
        step();
        chk_all_zero("bubble");

        // Reload then hold for three cycles while the MEM inputs change
        stall = 6'b000000;
        step();
        chk("reload.wdata", wb_wdata, 32'hDEADBEEF);
        stall = 6'b110000;
        for (int i = 0; i < 3; i++) begin
            mem_wdata = 32'h1000_0000 + 32'(i);
            mem_wd = 5'(i + 7);
            step();
            chk("hold.wdata", wb_wdata, 32'hDEADBEEF);
            chk("hold.wd", 32'(wb_wd), 32'd3);
            chk("hold.wreg", 32'(wb_wreg), 32'd1);
        end

        // WB stalled but MEM not: still an advance
        stall = 6'b100000; mem_wdata = 32'h12345678; mem_wd = 5'd9;
        step();
        chk("adv_s5.wdata", wb_wdata, 32'h12345678);
        chk("adv_s5.wd", 32'(wb_wd), 32'd9);

        // LL: bypass visible in the cycle the write sits in WB
        stall = 6'b000000; mem_LLbit_we = 1; mem_LLbit_value = 1;
        step();
        chk("ll.we", 32'(wb_LLbit_we), 32'd1);
        chk("ll.bypass", 32'(llbit_o), 32'd1);
        chk("ll.q_before", 32'(dut.llbit_q), 32'd0);
        mem_LLbit_we = 0; mem_LLbit_value = 0;
        step();
        chk("ll.q_after", 32'(dut.llbit_q), 32'd1);
        chk("ll.we_off", 32'(wb_LLbit_we), 32'd0);
        chk("ll.o_after", 32'(llbit_o), 32'd1);

        // Hold with a pending LLbit write of 0: output stays at the bypassed 0
        mem_LLbit_we = 1; mem_LLbit_value = 0; mem_wreg = 1;
        step();
        chk("ll0.bypass", 32'(llbit_o), 32'd0);
        stall = 6'b110000; mem_LLbit_we = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("llhold.o", 32'(llbit_o), 32'd0);
            chk("llhold.q", 32'(dut.llbit_q), 32'd0);
            chk("llhold.we", 32'(wb_LLbit_we), 32'd1);
        end

        // Re-arm LLbit=1 with a pending write, then flush while stalled
        stall = 6'b000000; mem_LLbit_we = 1; mem_LLbit_value = 1;
        step();
        step();
        chk("preflush.q", 32'(dut.llbit_q), 32'd1);
        chk("preflush.wreg", 32'(wb_wreg), 32'd1);
        chk("preflush.ll_we", 32'(wb_LLbit_we), 32'd1);
        flush = 1; stall = 6'b110000;
        step();
        chk_all_zero("flush");
        chk("flush.q", 32'(dut.llbit_q), 32'd0);
        chk("flush.o", 32'(llbit_o), 32'd0);
        flush = 0; stall = 6'b000000;

        // HI/LO and CP0
        clear_inputs();
        mem_whilo = 1; mem_hi = 32'h1; mem_lo = 32'h2;
        mem_cp0_reg_we = 1; mem_cp0_reg_waddr = 5'd12; mem_cp0_reg_wdata = 32'h0000FF01;
        step();
        chk("hilo.whilo", 32'(wb_whilo), 32'd1);
        chk("hilo.hi", wb_hi, 32'h1);
        chk("hilo.lo", wb_lo, 32'h2);
        chk("cp0.we", 32'(wb_cp0_reg_we), 32'd1);
        chk("cp0.waddr", 32'(wb_cp0_reg_waddr), 32'd12);
        chk("cp0.wdata", wb_cp0_reg_wdata, 32'h0000FF01);

        // Full-width values, top bits set
        mem_hi = 32'hFFFF_FFFF; mem_lo = 32'h8000_0001; mem_cp0_reg_wdata = 32'hA5A5_5A5A;
        mem_cp0_reg_waddr = 5'd31; mem_wd = 5'd31; mem_wdata = 32'hFEDC_BA98;
        step();
        chk("wide.hi", wb_hi, 32'hFFFF_FFFF);
        chk("wide.lo", wb_lo, 32'h8000_0001);
        chk("wide.cp0", wb_cp0_reg_wdata, 32'hA5A5_5A5A);
        chk("wide.waddr", 32'(wb_cp0_reg_waddr), 32'd31);
        chk("wide.wd", 32'(wb_wd), 32'd31);
        chk("wide.wdata", wb_wdata, 32'hFEDC_BA98);

        // Set LLbit, then reset in the middle of a stall
        mem_LLbit_we = 1; mem_LLbit_value = 1;
        step();
        mem_LLbit_we = 0;
        step();
        chk("prerst.q", 32'(dut.llbit_q), 32'd1);
        stall = 6'b110000; rst = 1;
        step();
        chk_all_zero("rst_mid");
        chk("rst_mid.q", 32'(dut.llbit_q), 32'd0);
        chk("rst_mid.o", 32'(llbit_o), 32'd0);

        // First advance after reset captures normally
        rst = 0; stall = 6'b000000;
        clear_inputs();
        mem_wd = 5'd17; mem_wreg = 1; mem_wdata = 32'hA5A5A5A5;
        step();
        chk("post_rst.wd", 32'(wb_wd), 32'd17);
        chk("post_rst.wreg", 32'(wb_wreg), 32'd1);
        chk("post_rst.wdata", wb_wdata, 32'hA5A5A5A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb.md
MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 SHALL provide one clock and synchronous active-high reset, listed first: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have input stall  in  6  pipeline stall vector; bit 4 = MEM stage, bit 5 = WB stage; 1 = stop.
REQ-003 SHALL have input flush  in  1  exception flush, 1 = clear.
REQ-004 SHALL have inputs mem_wd  in  5  GPR dest; mem_wreg  in  1  GPR write enable; mem_wdata  in  32  GPR write data.
REQ-005 SHALL have inputs mem_whilo  in  1  HI/LO write enable; mem_hi  in  32; mem_lo  in  32.
REQ-006 SHALL have inputs mem_LLbit_we  in  1  LLbit write enable; mem_LLbit_value  in  1  LLbit new value.
REQ-007 SHALL have inputs mem_cp0_reg_we  in  1; mem_cp0_reg_waddr  in  5; mem_cp0_reg_wdata  in  32.
REQ-008 SHALL have registered outputs wb_wd 5, wb_wreg 1, wb_wdata 32, wb_whilo 1, wb_hi 32, wb_lo 32, wb_LLbit_we 1, wb_LLbit_value 1, wb_cp0_reg_we 1, wb_cp0_reg_waddr 5, wb_cp0_reg_wdata 32, each mirroring its mem_* input.
REQ-009 SHALL have output llbit_o  out  1  current LLbit as seen by the MEM stage (bypassed).

Function
REQ-010 Pipeline register SHALL update only on rising clk; priority order, highest first: rst, flush, bubble, advance, hold.
REQ-011 rst=1 SHALL load every wb_* output with 0; wb_wd = 5'b00000 (NOP register).
REQ-012 flush=1 (rst=0) SHALL load every wb_* output with 0, regardless of stall.
REQ-013 Bubble: stall[4]=1 and stall[5]=0 SHALL load every wb_* output with 0, so no GPR, HI/LO, LLbit or CP0 write is issued.
REQ-014 Advance: stall[4]=0 SHALL copy every mem_* input to its wb_* output; latency exactly one cycle.
REQ-015 Hold: stall[4]=1 and stall[5]=1 SHALL keep every wb_* output unchanged.
REQ-016 Write-enable outputs SHALL never be 1 in the cycle after rst, flush or bubble.
REQ-017 Internal LLbit register llbit_q SHALL, on rising clk: rst -> 0; else flush -> 0; else wb_LLbit_we=1 -> wb_LLbit_value; else hold.
REQ-018 llbit_o SHALL be combinational: wb_LLbit_we ? wb_LLbit_value : llbit_q.
REQ-019 When flush=1 coincides with wb_LLbit_we=1, llbit_q SHALL become 0; the clear wins.
REQ-020 In a hold cycle with wb_LLbit_we=1, llbit_q SHALL rewrite the same value each cycle; llbit_o SHALL remain stable.
REQ-021 Values SHALL pass through at full width, with no truncation or sign change.

Reset
REQ-022 Reset SHALL be synchronous: an rst pulse of one clk cycle SHALL clear all wb_* outputs and llbit_q at that edge, including mid-stall.
REQ-023 After rst deasserts, the first advance edge SHALL capture mem_* inputs normally.
REQ-024 No output SHALL be X after the first clock edge with rst=1.

Verification
REQ-025 Advance: rst, then mem_wd=5'd3, mem_wreg=1, mem_wdata=32'hDEADBEEF, stall=0 -> next edge wb_wd=3, wb_wreg=1, wb_wdata=32'hDEADBEEF.
REQ-026 Bubble/hold:
- Load as in REQ-025.
- stall=6'b010000 -> next edge all wb_* = 0.
- Reload, then stall=6'b110000 for 3 cycles with mem_wdata changing -> wb_wdata holds 32'hDEADBEEF.
REQ-027 LL/SC:
- mem_LLbit_we=1, mem_LLbit_value=1, advance -> llbit_o=1 in the same cycle, via bypass.
- Next edge with mem_LLbit_we=0 -> llbit_q=1, llbit_o=1.
REQ-028 Flush:
- llbit_q=1 and wb_wreg=1; assert flush=1 with stall=6'b110000 -> next edge all wb_* = 0, llbit_q=0, llbit_o=0.
REQ-029 HI/LO and CP0:
- mem_whilo=1, mem_hi=32'h1, mem_lo=32'h2, mem_cp0_reg_we=1, mem_cp0_reg_waddr=5'd12, mem_cp0_reg_wdata=32'h0000FF01, advance -> all six values appear on wb_* after one edge.
- Then rst=1 -> all wb_* = 0.
